// File: rtl/alu_seq.sv
// Sequential N-bit ALU: single-cycle arithmetic/shift/logic plus iterative
// shift-add multiply and restoring divide, with valid/ready on both sides.
module alu_seq #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   func,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic [N-1:0] yhigh,
    output logic         co,
    output logic         zero,
    output logic         overflow,
    output logic         negative
);

    localparam int SW = $clog2(N);
    localparam logic [SW-1:0] LAST = SW'(N - 1);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  cnt_q, cnt_d;
    logic           isDiv_q, isDiv_d;
    logic           isSigned_q, isSigned_d;
    logic           negRes_q, negRes_d;
    logic           remNeg_q, remNeg_d;
    logic           bZero_q, bZero_d;
    logic           minOvf_q, minOvf_d;
    logic [N-1:0]   aOrig_q, aOrig_d;
    logic [N-1:0]   opB_q, opB_d;
    logic [N-1:0]   hi_q, hi_d;
    logic [N-1:0]   lo_q, lo_d;
    logic [N-1:0]   y_q, y_d;
    logic [N-1:0]   yhigh_q, yhigh_d;
    logic           co_q, co_d;
    logic           zero_q, zero_d;
    logic           ovf_q, ovf_d;
    logic           neg_q, neg_d;

    logic [SW-1:0]  s;
    logic [N:0]     sum;
    logic [N:0]     shlT;
    logic [N:0]     shrT;
    logic [2*N-1:0] rotT;
    logic [N-1:0]   scY;
    logic           scCo;
    logic           scOvf;

    assign s = b[SW-1:0];

    always_comb begin
        sum   = '0;
        shlT  = '0;
        shrT  = '0;
        rotT  = '0;
        scY   = '0;
        scCo  = 1'b0;
        scOvf = 1'b0;
        case (func)
            4'b0000, 4'b0001: begin
                sum   = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, func[0] & ci};
                scY   = sum[N-1:0];
                scCo  = sum[N];
                scOvf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
            end
            4'b0010, 4'b0011: begin
                sum   = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, func[0] & ci};
                scY   = sum[N-1:0];
                scCo  = sum[N];
                scOvf = (a[N-1] != b[N-1]) && (sum[N-1] != a[N-1]);
            end
            // The extra bit beside the data catches the last bit shifted out.
            4'b1000: begin
                shlT = {1'b0, a} << s;
                scY  = shlT[N-1:0];
                scCo = shlT[N];
            end
            4'b1001: begin
                shrT = {a, 1'b0} >> s;
                scY  = shrT[N:1];
                scCo = shrT[0];
            end
            4'b1010: begin
                rotT = {a, a} << s;
                scY  = rotT[2*N-1:N];
            end
            4'b1011: begin
                rotT = {a, a} >> s;
                scY  = rotT[N-1:0];
            end
            4'b1100: scY = a & b;
            4'b1101: scY = a | b;
            4'b1110: scY = a ^ b;
            4'b1111: scY = ~a;
            default: scY = '0;
        endcase
    end

    logic           aNeg;
    logic           bNeg;
    logic [N-1:0]   aMag;
    logic [N-1:0]   bMag;

    always_comb begin
        aNeg = ~func[0] & a[N-1];
        bNeg = ~func[0] & b[N-1];
        aMag = aNeg ? -a : a;
        bMag = bNeg ? -b : b;
    end

    logic [N:0]     mulSum;
    logic [N:0]     divShift;
    logic [N-1:0]   divSub;
    logic           divGe;
    logic [N-1:0]   stepHi;
    logic [N-1:0]   stepLo;

    always_comb begin
        mulSum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opB_q} : {(N+1){1'b0}});
        divShift = {hi_q, lo_q[N-1]};
        divGe    = divShift >= {1'b0, opB_q};
        divSub   = divShift[N-1:0] - opB_q;
        if (isDiv_q) begin
            stepHi = divGe ? divSub : divShift[N-1:0];
            stepLo = {lo_q[N-2:0], divGe};
        end else begin
            stepHi = mulSum[N:1];
            stepLo = {mulSum[0], lo_q[N-1:1]};
        end
    end

    logic [2*N-1:0] prod;
    logic [N-1:0]   finY;
    logic [N-1:0]   finYh;
    logic           finOvf;

    // Iteration runs on magnitudes; signs are restored only on the last step.
    always_comb begin
        prod   = '0;
        finY   = '0;
        finYh  = '0;
        finOvf = 1'b0;
        if (isDiv_q) begin
            if (bZero_q) begin
                finY   = '1;
                finYh  = aOrig_q;
                finOvf = 1'b1;
            end else begin
                finY   = negRes_q ? -stepLo : stepLo;
                finYh  = remNeg_q ? -stepHi : stepHi;
                finOvf = minOvf_q;
            end
        end else begin
            prod   = negRes_q ? -{stepHi, stepLo} : {stepHi, stepLo};
            finY   = prod[N-1:0];
            finYh  = prod[2*N-1:N];
            finOvf = isSigned_q ? (finYh != {N{finY[N-1]}}) : (finYh != '0);
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        isDiv_d    = isDiv_q;
        isSigned_d = isSigned_q;
        negRes_d   = negRes_q;
        remNeg_d   = remNeg_q;
        bZero_d    = bZero_q;
        minOvf_d   = minOvf_q;
        aOrig_d    = aOrig_q;
        opB_d      = opB_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        y_d        = y_q;
        yhigh_d    = yhigh_q;
        co_d       = co_q;
        zero_d     = zero_q;
        ovf_d      = ovf_q;
        neg_d      = neg_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (func[3:2] == 2'b01) begin
                        state_d    = ITER;
                        cnt_d      = '0;
                        isDiv_d    = func[1];
                        isSigned_d = ~func[0];
                        negRes_d   = aNeg ^ bNeg;
                        remNeg_d   = aNeg;
                        bZero_d    = (b == '0);
                        minOvf_d   = ~func[0] & func[1] & (a == {1'b1, {(N-1){1'b0}}}) & (b == '1);
                        aOrig_d    = a;
                        hi_d       = '0;
                        lo_d       = func[1] ? aMag : bMag;
                        opB_d      = func[1] ? bMag : aMag;
                    end else begin
                        state_d = DONE;
                        y_d     = scY;
                        yhigh_d = '0;
                        co_d    = scCo;
                        ovf_d   = scOvf;
                        zero_d  = (scY == '0);
                        neg_d   = scY[N-1];
                    end
                end
            end
            ITER: begin
                hi_d  = stepHi;
                lo_d  = stepLo;
                cnt_d = cnt_q + SW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    y_d     = finY;
                    yhigh_d = finYh;
                    co_d    = 1'b0;
                    ovf_d   = finOvf;
                    zero_d  = ({finYh, finY} == '0);
                    neg_d   = isDiv_q ? finY[N-1] : finYh[N-1];
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            isDiv_q    <= 1'b0;
            isSigned_q <= 1'b0;
            negRes_q   <= 1'b0;
            remNeg_q   <= 1'b0;
            bZero_q    <= 1'b0;
            minOvf_q   <= 1'b0;
            aOrig_q    <= '0;
            opB_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            y_q        <= '0;
            yhigh_q    <= '0;
            co_q       <= 1'b0;
            zero_q     <= 1'b0;
            ovf_q      <= 1'b0;
            neg_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            isDiv_q    <= isDiv_d;
            isSigned_q <= isSigned_d;
            negRes_q   <= negRes_d;
            remNeg_q   <= remNeg_d;
            bZero_q    <= bZero_d;
            minOvf_q   <= minOvf_d;
            aOrig_q    <= aOrig_d;
            opB_q      <= opB_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            y_q        <= y_d;
            yhigh_q    <= yhigh_d;
            co_q       <= co_d;
            zero_q     <= zero_d;
            ovf_q      <= ovf_d;
            neg_q      <= neg_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = y_q;
    assign yhigh     = yhigh_q;
    assign co        = co_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;
    assign negative  = neg_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (N=16): hand-computed results, latencies,
// backpressure hold and asynchronous reset during a divide.
module tb_alu_seq;

    localparam int N = 16;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [3:0]   func      = 4'h0;
    logic [N-1:0] a         = '0;
    logic [N-1:0] b         = '0;
    logic         ci        = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] y;
    logic [N-1:0] yhigh;
    logic         co;
    logic         zero;
    logic         overflow;
    logic         negative;

    int passCount  = 0;
    int checkCount = 0;

    always #5 clk = ~clk;

    alu_seq #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .func      (func),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .yhigh     (yhigh),
        .co        (co),
        .zero      (zero),
        .overflow  (overflow),
        .negative  (negative)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input string tag, input logic [3:0] f, input logic [N-1:0] aa,
                                 input logic [N-1:0] bb, input logic cc);
        checkOutput({tag, "_inready"}, 32'(in_ready), 32'd1);
        func     = f;
        a        = aa;
        b        = bb;
        ci       = cc;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid, watching in_ready stays low.
    task automatic waitResult(input string tag, input int expEdges);
        int   cycles;
        logic readyLow;
        cycles   = 0;
        readyLow = 1'b1;
        while (out_valid !== 1'b1 && cycles < 64) begin
            if (in_ready !== 1'b0) readyLow = 1'b0;
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput({tag, "_latency"}, 32'(cycles), 32'(expEdges));
        checkOutput({tag, "_busy"}, {31'd0, readyLow & (in_ready === 1'b0)}, 32'd1);
    endtask

    task automatic checkResult(input string tag, input logic [N-1:0] expY, input logic [N-1:0] expYh,
                               input logic [3:0] expFlags);
        checkOutput({tag, "_y"}, 32'(y), 32'(expY));
        checkOutput({tag, "_yhigh"}, 32'(yhigh), 32'(expYh));
        checkOutput({tag, "_flags"}, 32'({co, zero, overflow, negative}), 32'(expFlags));
    endtask

    task automatic takeResult(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, "_release"}, 32'({out_valid, in_ready}), 32'b01);
    endtask

    initial begin
        $display("[TB] start");
        #1;
        checkOutput("rst_hs", 32'({out_valid, in_ready}), 32'b01);
        checkResult("rst", 16'h0000, 16'h0000, 4'b0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // flags are {co, zero, overflow, negative}
        applyStimulus("add", 4'b0000, 16'h7FFF, 16'h0001, 1'b0);
        waitResult("add", 0);
        checkResult("add", 16'h8000, 16'h0000, 4'b0011);
        takeResult("add");

        applyStimulus("sbc", 4'b0011, 16'h0000, 16'h0000, 1'b1);
        waitResult("sbc", 0);
        checkResult("sbc", 16'hFFFF, 16'h0000, 4'b1001);
        takeResult("sbc");

        applyStimulus("addwrap", 4'b0000, 16'hFFFF, 16'h0001, 1'b1);
        waitResult("addwrap", 0);
        checkResult("addwrap", 16'h0000, 16'h0000, 4'b1100);
        takeResult("addwrap");

        applyStimulus("sub", 4'b0010, 16'h8000, 16'h0001, 1'b0);
        waitResult("sub", 0);
        checkResult("sub", 16'h7FFF, 16'h0000, 4'b0010);
        takeResult("sub");

        applyStimulus("mul", 4'b0100, 16'hFFFE, 16'h0003, 1'b0);
        waitResult("mul", 16);
        checkResult("mul", 16'hFFFA, 16'hFFFF, 4'b0001);
        takeResult("mul");

        applyStimulus("mulu", 4'b0101, 16'hFFFF, 16'hFFFF, 1'b0);
        waitResult("mulu", 16);
        checkResult("mulu", 16'h0001, 16'hFFFE, 4'b0011);
        takeResult("mulu");

        applyStimulus("div", 4'b0110, 16'hFFF9, 16'h0002, 1'b0);
        waitResult("div", 16);
        checkResult("div", 16'hFFFD, 16'hFFFF, 4'b0001);
        takeResult("div");

        applyStimulus("divu0", 4'b0111, 16'h0064, 16'h0000, 1'b0);
        waitResult("divu0", 16);
        checkResult("divu0", 16'hFFFF, 16'h0064, 4'b0011);
        takeResult("divu0");

        applyStimulus("divmin", 4'b0110, 16'h8000, 16'hFFFF, 1'b0);
        waitResult("divmin", 16);
        checkResult("divmin", 16'h8000, 16'h0000, 4'b0011);
        takeResult("divmin");

        applyStimulus("shl0", 4'b1000, 16'h8001, 16'h0000, 1'b0);
        waitResult("shl0", 0);
        checkResult("shl0", 16'h8001, 16'h0000, 4'b0001);
        takeResult("shl0");

        applyStimulus("shl1", 4'b1000, 16'h8001, 16'h0001, 1'b0);
        waitResult("shl1", 0);
        checkResult("shl1", 16'h0002, 16'h0000, 4'b1000);
        takeResult("shl1");

        applyStimulus("ror", 4'b1011, 16'h0001, 16'h0004, 1'b0);
        waitResult("ror", 0);
        checkResult("ror", 16'h1000, 16'h0000, 4'b0000);
        takeResult("ror");

        applyStimulus("not", 4'b1111, 16'h0000, 16'h1234, 1'b0);
        waitResult("not", 0);
        checkResult("not", 16'hFFFF, 16'h0000, 4'b0001);
        takeResult("not");

        applyStimulus("shr", 4'b1001, 16'h8001, 16'h0001, 1'b0);
        waitResult("shr", 0);
        checkResult("shr", 16'h4000, 16'h0000, 4'b1000);
        for (int i = 0; i < 5; i++) begin
            func     = 4'b1100;
            a        = 16'h5555;
            b        = 16'hFFFF;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            checkOutput($sformatf("hold%0d_y", i), 32'(y), 32'h4000);
            checkOutput($sformatf("hold%0d_vrc", i), 32'({out_valid, in_ready, co}), 32'b101);
        end
        in_valid = 1'b0;
        takeResult("shr");

        applyStimulus("divrst", 4'b0110, 16'h1234, 16'h0007, 1'b0);
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        checkOutput("divrst_hs", 32'({out_valid, in_ready}), 32'b01);
        checkResult("divrst", 16'h0000, 16'h0000, 4'b0000);
        @(posedge clk);
        #1;
        checkOutput("divrst_hold", 32'({out_valid, in_ready}), 32'b01);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus("and", 4'b1100, 16'hF0F0, 16'h0FF0, 1'b0);
        waitResult("and", 0);
        checkResult("and", 16'h00F0, 16'h0000, 4'b0000);
        takeResult("and");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
